idma_desc_submit_arbiter: RTL and testbench

Shares the single iDMA desc64 frontend register port between NumReq software/hardware requesters.
- Each requester submits the base address of a descriptor chain.
- The block round-robin arbitrates and issues one register-bus write of that address to the frontend descriptor-address register.
- It tracks submission order in an ID FIFO and routes each frontend completion interrupt back to the originating requester as a done pulse.

---
 rtl/idma_desc_submit_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_idma_desc_submit_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idma_desc_submit_arbiter.sv
// Purpose : share the iDMA desc64 frontend DESC_ADDR register between NumReq requesters,
// Latency : grant in IDLE (comb), bus write next cycle, one RESP cycle; done_o one cycle after irq_i.
// Backpr. : reg_ready_i low holds the write stable; no grants while MaxOutstanding chains are in flight.
//
// Ports:
//   clk_i, rst (async, active-high)
//   req_valid_i / req_addr_i / req_ready_o : per-requester chain submission (addr slice i = requester i)
//   reg_*                                  : register-bus write of the chain address to DescAddrOffset
//   irq_i                                  : frontend chain-complete pulse
//   done_o / err_o                         : one-hot completion / rejection pulses back to requesters
//   busy_o, spurious_irq_o                 : status (spurious is sticky until reset)
// Optional macro IDMA_SUBMIT_PERF_EN adds perf_submit_cnt_o / perf_done_cnt_o saturating counters.
module idma_desc_submit_arbiter #(
    parameter int unsigned           NumReq         = 4,
    parameter int unsigned           AddrWidth      = 64,
    parameter int unsigned           DataWidth      = 64,
    parameter logic [AddrWidth-1:0]  DescAddrOffset = '0,
    parameter int unsigned           MaxOutstanding = 4
) (
    input  logic                        clk_i,
    input  logic                        rst,
    input  logic [NumReq-1:0]           req_valid_i,
    input  logic [NumReq*AddrWidth-1:0] req_addr_i,
    output logic [NumReq-1:0]           req_ready_o,
    output logic [AddrWidth-1:0]        reg_addr_o,
    output logic                        reg_write_o,
    output logic [DataWidth-1:0]        reg_wdata_o,
    output logic [DataWidth/8-1:0]      reg_wstrb_o,
    output logic                        reg_valid_o,
    input  logic                        reg_ready_i,
    input  logic                        reg_error_i,
    input  logic                        irq_i,
    output logic [NumReq-1:0]           done_o,
    output logic [NumReq-1:0]           err_o,
    output logic                        busy_o,
    output logic                        spurious_irq_o
`ifdef IDMA_SUBMIT_PERF_EN
    ,
    output logic [31:0]                 perf_submit_cnt_o,
    output logic [31:0]                 perf_done_cnt_o
`endif
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding) + 1;

    typedef enum logic [1:0] {StIdle, StWrite, StResp} state_e;

    state_e                 state_q, state_d;
    logic [IdxW-1:0]        rr_q, rr_d;
    logic [IdxW-1:0]        gnt_id_q, gnt_id_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [NumReq-1:0]      err_q, err_d;
    logic [NumReq-1:0]      done_q, done_d;
    logic                   spur_q, spur_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [PtrW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
    logic [IdxW-1:0]        mem_q [MaxOutstanding];

    logic                   gnt_vld, can_grant, push, pop;
    logic [IdxW-1:0]        gnt_idx;
    logic [AddrWidth-1:0]   gnt_addr;

    // Round-robin pick: first pass looks at indices >= rr_q, second pass wraps to the lowest valid.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        gnt_addr = '0;
        for (int j = 0; j < NumReq; j++) begin
            if (!gnt_vld && req_valid_i[j] && (IdxW'(j) >= rr_q)) begin
                gnt_vld  = 1'b1;
                gnt_idx  = IdxW'(j);
                gnt_addr = req_addr_i[j*AddrWidth +: AddrWidth];
            end
        end
        for (int j = 0; j < NumReq; j++) begin
            if (!gnt_vld && req_valid_i[j]) begin
                gnt_vld  = 1'b1;
                gnt_idx  = IdxW'(j);
                gnt_addr = req_addr_i[j*AddrWidth +: AddrWidth];
            end
        end
    end

    // Registered count only: a slot freed by this cycle's pop is usable from the next cycle.
    assign can_grant   = (state_q == StIdle) && gnt_vld && (cnt_q < CntW'(MaxOutstanding));
    assign req_ready_o = can_grant ? (NumReq'(1) << gnt_idx) : '0;

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        gnt_id_d = gnt_id_q;
        addr_d   = addr_q;
        err_d    = '0;
        push     = 1'b0;
        case (state_q)
            StIdle: begin
                if (can_grant) begin
                    gnt_id_d = gnt_idx;
                    addr_d   = gnt_addr;
                    rr_d     = (gnt_idx == IdxW'(NumReq - 1)) ? '0 : gnt_idx + IdxW'(1);
                    // All-ones address is the reject sentinel: bounce it without touching the bus.
                    if (&gnt_addr) err_d   = NumReq'(1) << gnt_idx;
                    else           state_d = StWrite;
                end
            end
            StWrite: begin
                if (reg_ready_i) begin
                    state_d = StResp;
                    if (reg_error_i) err_d = NumReq'(1) << gnt_id_q;
                    else             push  = 1'b1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign pop    = irq_i && (cnt_q != '0);
    assign done_d = pop ? (NumReq'(1) << mem_q[rptr_q]) : '0;
    assign spur_d = spur_q | (irq_i && (cnt_q == '0));
    assign wptr_d = push ? ((wptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wptr_q + PtrW'(1)) : wptr_q;
    assign rptr_d = pop  ? ((rptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rptr_q + PtrW'(1)) : rptr_q;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + CntW'(1);
        else if (pop && !push) cnt_d = cnt_q - CntW'(1);
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            rr_q     <= '0;
            gnt_id_q <= '0;
            addr_q   <= '0;
            err_q    <= '0;
            done_q   <= '0;
            spur_q   <= 1'b0;
            cnt_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            for (int i = 0; i < MaxOutstanding; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            gnt_id_q <= gnt_id_d;
            addr_q   <= addr_d;
            err_q    <= err_d;
            done_q   <= done_d;
            spur_q   <= spur_d;
            cnt_q    <= cnt_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            if (push) mem_q[wptr_q] <= gnt_id_q;
        end
    end

    // Bus fields are gated so everything reads zero outside the write phase.
    assign reg_valid_o    = (state_q == StWrite);
    assign reg_write_o    = (state_q == StWrite);
    assign reg_addr_o     = (state_q == StWrite) ? DescAddrOffset : '0;
    assign reg_wdata_o    = (state_q == StWrite) ? addr_q : '0;
    assign reg_wstrb_o    = (state_q == StWrite) ? '1 : '0;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign busy_o         = (state_q != StIdle) || (cnt_q != '0);
    assign spurious_irq_o = spur_q;

`ifdef IDMA_SUBMIT_PERF_EN
    logic [31:0] perf_submit_q, perf_done_q;
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            perf_submit_q <= '0;
            perf_done_q   <= '0;
        end else begin
            if (push && (perf_submit_q != '1)) perf_submit_q <= perf_submit_q + 32'd1;
            if ((|done_q) && (perf_done_q != '1)) perf_done_q <= perf_done_q + 32'd1;
        end
    end
    assign perf_submit_cnt_o = perf_submit_q;
    assign perf_done_cnt_o   = perf_done_q;
`endif

endmodule

// File: tb/tb_idma_desc_submit_arbiter.sv
// Bench for idma_desc_submit_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model (rr pointer, outstanding-id queue).
// Inputs change 2 time units after a rising edge; outputs are sampled 1 unit later.
module tb_idma_desc_submit_arbiter;

    localparam int N = 4;

    logic            clk_i = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid_i;
    logic [N*64-1:0] req_addr_i;
    logic [N-1:0]    req_ready_o;
    logic [63:0]     reg_addr_o;
    logic            reg_write_o;
    logic [63:0]     reg_wdata_o;
    logic [7:0]      reg_wstrb_o;
    logic            reg_valid_o;
    logic            reg_ready_i;
    logic            reg_error_i;
    logic            irq_i;
    logic [N-1:0]    done_o;
    logic [N-1:0]    err_o;
    logic            busy_o;
    logic            spurious_irq_o;

    int vectors = 0;
    int miscompares = 0;

    idma_desc_submit_arbiter dut (
        .clk_i(clk_i), .rst(rst),
        .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_ready_o(req_ready_o),
        .reg_addr_o(reg_addr_o), .reg_write_o(reg_write_o), .reg_wdata_o(reg_wdata_o),
        .reg_wstrb_o(reg_wstrb_o), .reg_valid_o(reg_valid_o), .reg_ready_i(reg_ready_i),
        .reg_error_i(reg_error_i), .irq_i(irq_i), .done_o(done_o), .err_o(err_o),
        .busy_o(busy_o), .spurious_irq_o(spurious_irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid_i = '0;
        irq_i = 1'b0;
        reg_ready_i = 1'b1;
        reg_error_i = 1'b0;
        #1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid_i = '0;
        req_addr_i = '0;
        irq_i = 1'b0;
        reg_ready_i = 1'b0;
        reg_error_i = 1'b0;
        #3;
        vectors++; if (reg_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_reg_valid got %b exp 0", reg_valid_o); end
        vectors++; if (req_ready_o !== 4'b0) begin miscompares++; $display("FAIL reset_req_ready got %b exp 0000", req_ready_o); end
        vectors++; if ({done_o, err_o} !== 8'b0) begin miscompares++; $display("FAIL reset_done_err got %b exp 0", {done_o, err_o}); end
        vectors++; if ({busy_o, spurious_irq_o} !== 2'b0) begin miscompares++; $display("FAIL reset_busy_spur got %b exp 00", {busy_o, spurious_irq_o}); end
        vectors++; if (reg_wdata_o !== 64'h0) begin miscompares++; $display("FAIL reset_wdata got %h exp 0", reg_wdata_o); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req_valid_i = 4'b0010;
        req_addr_i[64 +: 64] = 64'hF000000000000000;
        #1;
        vectors++; if (req_ready_o !== 4'b0010) begin miscompares++; $display("FAIL single_ready got %b exp 0010", req_ready_o); end
        tick();
        req_valid_i = '0;
        #1;
        vectors++; if ({reg_valid_o, reg_write_o} !== 2'b11) begin miscompares++; $display("FAIL single_valid got %b exp 11", {reg_valid_o, reg_write_o}); end
        vectors++; if (reg_addr_o !== 64'h0) begin miscompares++; $display("FAIL single_addr got %h exp 0", reg_addr_o); end
        vectors++; if (reg_wdata_o !== 64'hF000000000000000) begin miscompares++; $display("FAIL single_wdata got %h exp f000000000000000", reg_wdata_o); end
        vectors++; if (reg_wstrb_o !== 8'hFF) begin miscompares++; $display("FAIL single_wstrb got %h exp ff", reg_wstrb_o); end
        tick();
        #1;
        vectors++; if ({reg_valid_o, busy_o} !== 2'b01) begin miscompares++; $display("FAIL single_resp got %b exp 01", {reg_valid_o, busy_o}); end
        tick();
        irq_i = 1'b1;
        tick();
        irq_i = 1'b0;
        #1;
        vectors++; if (done_o !== 4'b0010) begin miscompares++; $display("FAIL single_done got %b exp 0010", done_o); end
        tick();
        #1;
        vectors++; if ({done_o, busy_o} !== 5'b0) begin miscompares++; $display("FAIL single_idle got %b exp 00000", {done_o, busy_o}); end
    endtask

    task automatic test_round_robin();
        int ngrant;
        do_reset();
        for (int i = 0; i < N; i++) req_addr_i[i*64 +: 64] = 64'hA000 + 64'(i) * 64'h100;
        req_valid_i = 4'hF;
        ngrant = 0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (|req_ready_o) begin
                vectors++; if (ngrant >= 4 || req_ready_o !== (4'b1 << ngrant)) begin miscompares++; $display("FAIL rr_grant got %b idx %0d", req_ready_o, ngrant); end
                ngrant++;
            end
            tick();
        end
        vectors++; if (ngrant != 4) begin miscompares++; $display("FAIL rr_count got %0d exp 4", ngrant); end
        irq_i = 1'b1;
        #1;
        vectors++; if (req_ready_o !== 4'b0) begin miscompares++; $display("FAIL rr_full_hold got %b exp 0000", req_ready_o); end
        tick();
        irq_i = 1'b0;
        #1;
        vectors++; if (done_o !== 4'b0001) begin miscompares++; $display("FAIL rr_done0 got %b exp 0001", done_o); end
        vectors++; if (req_ready_o !== 4'b0001) begin miscompares++; $display("FAIL rr_regrant got %b exp 0001", req_ready_o); end
        tick();
        req_valid_i = '0;
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            irq_i = 1'b1;
            tick();
            irq_i = 1'b0;
            #1;
            vectors++; if (done_o !== (4'b1 << ((k + 1) % 4))) begin miscompares++; $display("FAIL rr_done_order got %b step %0d", done_o, k); end
            tick();
        end
        #1;
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL rr_drained got %b exp 0", busy_o); end
    endtask

    task automatic test_backpressure();
        int hs;
        do_reset();
        req_valid_i = 4'b0001;
        req_addr_i[0 +: 64] = 64'h123456789ABCDEF0;
        reg_ready_i = 1'b0;
        #1;
        vectors++; if (req_ready_o !== 4'b0001) begin miscompares++; $display("FAIL bp_ready got %b exp 0001", req_ready_o); end
        tick();
        req_valid_i = '0;
        req_addr_i[0 +: 64] = 64'h0;
        for (int c = 0; c < 5; c++) begin
            #1;
            vectors++; if (reg_valid_o !== 1'b1 || reg_wdata_o !== 64'h123456789ABCDEF0) begin miscompares++; $display("FAIL bp_hold got %b %h cycle %0d", reg_valid_o, reg_wdata_o, c); end
            tick();
        end
        reg_ready_i = 1'b1;
        hs = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (reg_valid_o && reg_ready_i) hs++;
            tick();
        end
        vectors++; if (hs != 1) begin miscompares++; $display("FAIL bp_writes got %0d exp 1", hs); end
        irq_i = 1'b1;
        tick();
        irq_i = 1'b0;
        #1;
        vectors++; if (done_o !== 4'b0001) begin miscompares++; $display("FAIL bp_done got %b exp 0001", done_o); end
    endtask

    task automatic test_error();
        do_reset();
        req_valid_i = 4'b0100;
        req_addr_i[128 +: 64] = 64'h2222;
        reg_error_i = 1'b1;
        #1;
        vectors++; if (req_ready_o !== 4'b0100) begin miscompares++; $display("FAIL err_ready got %b exp 0100", req_ready_o); end
        tick();
        req_valid_i = '0;
        #1;
        vectors++; if (reg_valid_o !== 1'b1) begin miscompares++; $display("FAIL err_write got %b exp 1", reg_valid_o); end
        tick();
        reg_error_i = 1'b0;
        #1;
        vectors++; if (err_o !== 4'b0100) begin miscompares++; $display("FAIL err_pulse got %b exp 0100", err_o); end
        tick();
        #1;
        vectors++; if ({err_o, busy_o} !== 5'b0) begin miscompares++; $display("FAIL err_nopush got %b exp 00000", {err_o, busy_o}); end
        irq_i = 1'b1;
        tick();
        irq_i = 1'b0;
        #1;
        vectors++; if ({spurious_irq_o, done_o} !== 5'b10000) begin miscompares++; $display("FAIL err_spurious got %b exp 10000", {spurious_irq_o, done_o}); end
    endtask

    task automatic test_sentinel();
        int writes;
        do_reset();
        req_valid_i = 4'b1000;
        req_addr_i[192 +: 64] = 64'hFFFFFFFFFFFFFFFF;
        #1;
        vectors++; if (req_ready_o !== 4'b1000) begin miscompares++; $display("FAIL sent_ready got %b exp 1000", req_ready_o); end
        tick();
        req_valid_i = '0;
        #1;
        vectors++; if (err_o !== 4'b1000) begin miscompares++; $display("FAIL sent_err got %b exp 1000", err_o); end
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL sent_busy got %b exp 0", busy_o); end
        writes = 0;
        for (int c = 0; c < 4; c++) begin
            if (reg_valid_o) writes++;
            tick();
            #1;
        end
        vectors++; if (writes != 0) begin miscompares++; $display("FAIL sent_nowrite got %0d exp 0", writes); end
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        req_valid_i = 4'b0001;
        req_addr_i[0 +: 64] = 64'h5555;
        reg_ready_i = 1'b0;
        tick();
        req_valid_i = '0;
        #1;
        vectors++; if (reg_valid_o !== 1'b1) begin miscompares++; $display("FAIL rmw_write got %b exp 1", reg_valid_o); end
        rst = 1'b1;
        #1;
        vectors++; if (reg_valid_o !== 1'b0) begin miscompares++; $display("FAIL rmw_drop got %b exp 0", reg_valid_o); end
        tick();
        rst = 1'b0;
        reg_ready_i = 1'b1;
        #1;
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL rmw_busy got %b exp 0", busy_o); end
        req_valid_i = 4'b0010;
        req_addr_i[64 +: 64] = 64'h7777;
        #1;
        vectors++; if (req_ready_o !== 4'b0010) begin miscompares++; $display("FAIL rmw_regrant got %b exp 0010", req_ready_o); end
        tick();
        req_valid_i = '0;
        #1;
        vectors++; if (reg_valid_o !== 1'b1 || reg_wdata_o !== 64'h7777) begin miscompares++; $display("FAIL rmw_newwrite got %b %h exp 1 7777", reg_valid_o, reg_wdata_o); end
        tick();
        tick();
        irq_i = 1'b1;
        tick();
        irq_i = 1'b0;
        #1;
        vectors++; if (done_o !== 4'b0010) begin miscompares++; $display("FAIL rmw_done got %b exp 0010", done_o); end
    endtask

    // Model: rr pointer, FIFO of outstanding requester ids, one in-flight write.
    task automatic test_random();
        int          rr;
        int          q[$];
        int          cur_id;
        int          g;
        logic [63:0] cur_addr;
        logic [N-1:0] exp_done, exp_err;
        logic        exp_spur, pending, resp_prev, resp_now, do_push, exp_grant;
        do_reset();
        rr = 0; cur_id = 0; cur_addr = '0;
        exp_done = '0; exp_err = '0; exp_spur = 1'b0;
        pending = 1'b0; resp_prev = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            vectors++; if (done_o !== exp_done) begin miscompares++; $display("FAIL rnd_done got %b exp %b cyc %0d", done_o, exp_done, cyc); end
            vectors++; if (err_o !== exp_err) begin miscompares++; $display("FAIL rnd_err got %b exp %b cyc %0d", err_o, exp_err, cyc); end
            vectors++; if (spurious_irq_o !== exp_spur) begin miscompares++; $display("FAIL rnd_spur got %b exp %b cyc %0d", spurious_irq_o, exp_spur, cyc); end
            exp_done = '0;
            exp_err  = '0;
            req_valid_i = N'($urandom_range(0, 15));
            for (int i = 0; i < N; i++)
                req_addr_i[i*64 +: 64] = ($urandom_range(0, 7) == 0) ? 64'hFFFFFFFFFFFFFFFF : {$urandom, $urandom};
            reg_ready_i = ($urandom_range(0, 2) != 0);
            reg_error_i = ($urandom_range(0, 7) == 0);
            irq_i       = ($urandom_range(0, 5) == 0);
            #1;
            vectors++; if (reg_valid_o !== pending) begin miscompares++; $display("FAIL rnd_valid got %b exp %b cyc %0d", reg_valid_o, pending, cyc); end
            exp_grant = !pending && !resp_prev && (|req_valid_i) && (q.size() < 4);
            vectors++; if ((|req_ready_o) !== exp_grant) begin miscompares++; $display("FAIL rnd_grant_when got %b exp %b cyc %0d", req_ready_o, exp_grant, cyc); end
            if (exp_grant) begin
                g = -1;
                for (int k = 0; k < N; k++)
                    if (g < 0 && req_valid_i[(rr + k) % N]) g = (rr + k) % N;
                vectors++; if (req_ready_o !== (N'(1) << g)) begin miscompares++; $display("FAIL rnd_grant_idx got %b exp idx %0d cyc %0d", req_ready_o, g, cyc); end
                cur_id   = g;
                cur_addr = req_addr_i[g*64 +: 64];
                rr       = (g + 1) % N;
                if (cur_addr == 64'hFFFFFFFFFFFFFFFF) exp_err = N'(1) << g;
                else pending = 1'b1;
            end
            resp_now = 1'b0;
            do_push  = 1'b0;
            if (reg_valid_o && reg_ready_i) begin
                vectors++; if (reg_wdata_o !== cur_addr) begin miscompares++; $display("FAIL rnd_wdata got %h exp %h cyc %0d", reg_wdata_o, cur_addr, cyc); end
                pending  = 1'b0;
                resp_now = 1'b1;
                if (reg_error_i) exp_err = N'(1) << cur_id;
                else do_push = 1'b1;
            end
            if (irq_i) begin
                if (q.size() > 0) exp_done = N'(1) << q.pop_front();
                else exp_spur = 1'b1;
            end
            if (do_push) q.push_back(cur_id);
            resp_prev = resp_now;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_error();
        test_sentinel();
        test_reset_mid_write();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
